// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    localparam int NIBBLE_W = 4;

    // Slice counter width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Request/result bundle between a client and the nibble-serial adder.
// Carries sub/ovf only when SERIAL_ADDER_SUB_EN is defined.
interface serial_nibble_adder_if #(
    parameter int NIBBLES = 4
);
    import serial_adder_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
    logic         ovf;
`endif

    modport master (
        output start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
        input  ovf,
`endif
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
        output ovf,
`endif
        output busy, done, sum, c_out
    );

endinterface

// File: rtl/serial_nibble_adder_stage.sv
// Combinational 4-bit add slice; also exposes the carry into
// the slice MSB so the top can derive signed overflow.
module nibble_adder_stage (
    input  logic [3:0] i_a4,
    input  logic [3:0] i_b4,
    input  logic       i_ci,
    output logic [3:0] o_s4,
    output logic       o_co,
    output logic       o_c3
);

    logic [4:0] w_full;

    assign w_full = {1'b0, i_a4} + {1'b0, i_b4} + {4'b0, i_ci};
    assign o_s4   = w_full[3:0];
    assign o_co   = w_full[4];
    // s3 = a3 ^ b3 ^ c3, so the MSB carry-in falls out of the sum bit
    assign o_c3   = o_s4[3] ^ i_a4[3] ^ i_b4[3];

endmodule

// File: rtl/serial_nibble_adder.sv
// Nibble-serial W-bit adder: one 4-bit slice per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub input and ovf output.
module serial_nibble_adder
    import serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_nibble_adder_if.slave bus
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_w(NIBBLES);

    sa_state_t r_state;
    sa_state_t w_state_nx;

    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic          r_c_out;
    logic [IW-1:0] r_idx;

    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic [3:0]    w_s4;
    logic          w_co;
    logic          w_msb_ci;
    logic [W-1:0]  w_acc_nx;
    logic [W-1:0]  w_b_cap;
    logic          w_c_cap;

    nibble_adder_stage u_stage (
        .i_a4 (r_a_sh[3:0]),
        .i_b4 (r_b_sh[3:0]),
        .i_ci (r_carry),
        .o_s4 (w_s4),
        .o_co (w_co),
        .o_c3 (w_msb_ci)
    );

    assign w_last   = (r_idx == IW'(NIBBLES - 1));
    // New nibble enters at the MSB end; after NIBBLES shifts it is aligned
    assign w_acc_nx = (r_acc >> NIBBLE_W) | (W'(w_s4) << (W - NIBBLE_W));

`ifdef SERIAL_ADDER_SUB_EN
    logic r_ovf;

    assign w_b_cap = bus.sub ? ~bus.b : bus.b;
    assign w_c_cap = bus.sub | bus.c_in;
    assign bus.ovf = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_run && w_last) begin
            r_ovf <= w_co ^ w_msb_ci;
        end
    end
`else
    logic w_unused;

    assign w_b_cap  = bus.b;
    assign w_c_cap  = bus.c_in;
    assign w_unused = w_msb_ci;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_run      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_state_nx = RUN;
            end
            RUN: begin
                w_run = 1'b1;
                if (w_last) w_state_nx = DONE;
            end
            DONE: begin
                w_accept   = bus.start;
                w_state_nx = bus.start ? RUN : IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= w_b_cap;
            r_carry <= w_c_cap;
            r_idx   <= '0;
        end else if (w_run) begin
            r_a_sh  <= r_a_sh >> NIBBLE_W;
            r_b_sh  <= r_b_sh >> NIBBLE_W;
            r_acc   <= w_acc_nx;
            r_carry <= w_co;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_sum   <= w_acc_nx;
                r_c_out <= w_co;
            end
        end
    end

    assign bus.busy  = (r_state == RUN);
    assign bus.done  = (r_state == DONE);
    assign bus.sum   = r_sum;
    assign bus.c_out = r_c_out;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder at NIBBLES=4 and NIBBLES=1.
// Subtract-mode vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_nibble_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   lat;
    int   bc;

    always #5 clk = ~clk;

    serial_nibble_adder_if #(.NIBBLES(4)) if4 ();
    serial_nibble_adder_if #(.NIBBLES(1)) if1 ();

    serial_nibble_adder #(.NIBBLES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    serial_nibble_adder #(.NIBBLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps until done, counting cycles and busy cycles; bounded.
    task automatic wait_done(input int which, output int l, output int b);
        l = 0;
        b = 0;
        while (((which == 0) ? !if4.done : !if1.done) && l < 40) begin
            if ((which == 0) ? if4.busy : if1.busy) b++;
            step();
            l++;
        end
    endtask

    initial begin
        if4.start = 0; if4.a = '0; if4.b = '0; if4.c_in = 0;
        if1.start = 0; if1.a = '0; if1.b = '0; if1.c_in = 0;
`ifdef SERIAL_ADDER_SUB_EN
        if4.sub = 0;
        if1.sub = 0;
`endif
        step();
        chk("rst_busy", 32'(if4.busy), 32'd0);
        chk("rst_done", 32'(if4.done), 32'd0);
        chk("rst_sum", 32'(if4.sum), 32'd0);
        chk("rst_cout", 32'(if4.c_out), 32'd0);
`ifdef SERIAL_ADDER_SUB_EN
        chk("rst_ovf", 32'(if4.ovf), 32'd0);
`endif
        rst_n = 1;
        step();

        // 1: 00FF + 0001
        if4.start = 1; if4.a = 16'h00FF; if4.b = 16'h0001; if4.c_in = 0;
        step();
        if4.start = 0;
        wait_done(0, lat, bc);
        chk("t1_done", 32'(if4.done), 32'd1);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_busy_cycles", 32'(bc), 32'd4);
        chk("t1_sum", 32'(if4.sum), 32'h0100);
        chk("t1_cout", 32'(if4.c_out), 32'd0);
`ifdef SERIAL_ADDER_SUB_EN
        chk("t1_ovf", 32'(if4.ovf), 32'd0);
`endif
        step();
        chk("t1_done_pulse", 32'(if4.done), 32'd0);
        chk("t1_idle_busy", 32'(if4.busy), 32'd0);
        chk("t1_sum_hold", 32'(if4.sum), 32'h0100);

        // 2: carry ripples through every slice
        if4.start = 1; if4.a = 16'hFFFF; if4.b = 16'h0000; if4.c_in = 1;
        step();
        if4.start = 0;
        if4.a = 16'h1111; if4.b = 16'h2222; if4.c_in = 0;
        wait_done(0, lat, bc);
        chk("t2_lat", 32'(lat), 32'd4);
        chk("t2_sum", 32'(if4.sum), 32'h0000);
        chk("t2_cout", 32'(if4.c_out), 32'd1);
        step();

        // 3: start held high, back-to-back adds
        if4.start = 1; if4.a = 16'd1; if4.b = 16'd2; if4.c_in = 0;
        step();
        wait_done(0, lat, bc);
        chk("t3a_lat", 32'(lat), 32'd4);
        chk("t3a_busy_cycles", 32'(bc), 32'd4);
        chk("t3a_sum", 32'(if4.sum), 32'd3);
        if4.a = 16'd3; if4.b = 16'd4;
        step();
        chk("t3b_busy", 32'(if4.busy), 32'd1);
        chk("t3b_done", 32'(if4.done), 32'd0);
        chk("t3b_sum_hold", 32'(if4.sum), 32'd3);
        wait_done(0, lat, bc);
        chk("t3b_lat", 32'(lat), 32'd4);
        chk("t3b_sum", 32'(if4.sum), 32'd7);
        chk("t3b_cout", 32'(if4.c_out), 32'd0);
        if4.start = 0;
        step();
        chk("t3_idle_busy", 32'(if4.busy), 32'd0);
        chk("t3_idle_done", 32'(if4.done), 32'd0);

        // 4: reset in the second RUN cycle
        if4.start = 1; if4.a = 16'h1234; if4.b = 16'h1111;
        step();
        if4.start = 0;
        step();
        chk("t4_busy_pre", 32'(if4.busy), 32'd1);
        rst_n = 0;
        #1;
        chk("t4_rst_busy", 32'(if4.busy), 32'd0);
        chk("t4_rst_done", 32'(if4.done), 32'd0);
        chk("t4_rst_sum", 32'(if4.sum), 32'd0);
        chk("t4_rst_cout", 32'(if4.c_out), 32'd0);
        #2;
        rst_n = 1;
        step();
        if4.start = 1;
        step();
        if4.start = 0;
        wait_done(0, lat, bc);
        chk("t4_lat", 32'(lat), 32'd4);
        chk("t4_sum", 32'(if4.sum), 32'h2345);
        chk("t4_cout", 32'(if4.c_out), 32'd0);
        step();

        // 5: single-nibble build
        if1.start = 1; if1.a = 4'hF; if1.b = 4'h1; if1.c_in = 0;
        step();
        if1.start = 0;
        wait_done(1, lat, bc);
        chk("t5_lat", 32'(lat), 32'd1);
        chk("t5_busy_cycles", 32'(bc), 32'd1);
        chk("t5_sum", 32'(if1.sum), 32'h0);
        chk("t5_cout", 32'(if1.c_out), 32'd1);
        step();

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtraction and signed overflow
        if4.start = 1; if4.sub = 1;
        if4.a = 16'h8000; if4.b = 16'h0001; if4.c_in = 0;
        step();
        if4.start = 0; if4.sub = 0;
        wait_done(0, lat, bc);
        chk("t6a_sum", 32'(if4.sum), 32'h7FFF);
        chk("t6a_cout", 32'(if4.c_out), 32'd1);
        chk("t6a_ovf", 32'(if4.ovf), 32'd1);
        step();
        if4.start = 1; if4.sub = 1;
        if4.a = 16'd5; if4.b = 16'd7;
        step();
        if4.start = 0; if4.sub = 0;
        wait_done(0, lat, bc);
        chk("t6b_sum", 32'(if4.sum), 32'hFFFE);
        chk("t6b_cout", 32'(if4.c_out), 32'd0);
        chk("t6b_ovf", 32'(if4.ovf), 32'd0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
